// File: rtl/lenet_frame_scheduler.sv
// Frame sequencer for the LeNet core: fetches a frame from pixel RAM, streams it, collects the result.
// Optional `LENET_SCHED_QUEUE_EN adds a 2-entry queue of pending frame base addresses.
module lenet_frame_scheduler #(
  parameter int unsigned I_SIZE1     = 32,
  parameter int unsigned I_BW1       = 8,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic              clk,
  input  logic              global_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_abort,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [I_BW1-1:0]  i_mem_rdata,
  output logic              o_core_ce,
  output logic [I_BW1-1:0]  o_core_fmap,
  output logic              o_core_rst_end,
  input  logic [3:0]        i_core_cls_result,
  input  logic              i_core_cls_en,
  input  logic              i_core_cls_end,
  output logic [3:0]        o_result,
  output logic              o_result_valid,
  output logic              o_done,
  output logic              o_error
);
  localparam int unsigned N     = I_SIZE1 * I_SIZE1;
  localparam int unsigned PIX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREFETCH, S_STREAM, S_COMPUTE, S_FLUSH
  } state_t;

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] base_q, base_n;
  logic [PIX_W-1:0]  pix_q, pix_n;
  logic [TO_W-1:0]   to_q, to_n;
  logic              got_q, got_n, err_q, err_n;
  logic              capture, aborting;

  logic              ready_q, ready_n, busy_q, busy_n, rd_en_q, rd_en_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              ce_q, ce_n, stream_q, stream_n, flush_q, flush_n, error_q, error_n;
  logic [3:0]        result_q;
  logic              rv_q;

`ifdef LENET_SCHED_QUEUE_EN
  logic [ADDR_W-1:0] fifo_q [2];
  logic [1:0]        fifo_cnt_q, fifo_cnt_n;
  logic              fifo_pop, fifo_push, direct_take, push_idx;
`endif

  // Next-state and next-output decode
  always_comb begin
    state_n  = state_q;
    base_n   = base_q;
    pix_n    = pix_q;
    to_n     = to_q;
    got_n    = got_q;
    err_n    = err_q;
    capture  = 1'b0;
    aborting = i_abort && (state_q inside {S_PREFETCH, S_STREAM, S_COMPUTE});
`ifdef LENET_SCHED_QUEUE_EN
    fifo_pop    = 1'b0;
    direct_take = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef LENET_SCHED_QUEUE_EN
        if (fifo_cnt_q != 2'd0) begin
          fifo_pop = 1'b1;
          base_n   = fifo_q[0];
          state_n  = S_PREFETCH;
        end else if (i_start) begin
          direct_take = 1'b1;
          base_n      = i_base_addr;
          state_n     = S_PREFETCH;
        end
`else
        if (i_start) begin
          base_n  = i_base_addr;
          state_n = S_PREFETCH;
        end
`endif
      end
      S_PREFETCH: begin
        pix_n   = '0;
        state_n = S_STREAM;
      end
      S_STREAM: begin
        if (pix_q == PIX_LAST) begin
          to_n    = '0;
          state_n = S_COMPUTE;
        end else begin
          pix_n = pix_q + PIX_W'(1);
        end
      end
      S_COMPUTE: begin
        to_n = to_q + TO_W'(1);
        if (i_core_cls_en) begin
          capture = 1'b1;
          got_n   = 1'b1;
        end
        // A result arriving with cls_end in the same cycle still counts
        if (i_core_cls_end) begin
          state_n = S_FLUSH;
          err_n   = !(got_q || i_core_cls_en);
        end else if (to_q == TO_LAST) begin
          state_n = S_FLUSH;
          err_n   = 1'b1;
        end
      end
      S_FLUSH: begin
        pix_n   = '0;
        to_n    = '0;
        got_n   = 1'b0;
        err_n   = 1'b0;
        state_n = S_IDLE;
`ifdef LENET_SCHED_QUEUE_EN
        if (fifo_cnt_q != 2'd0) begin
          fifo_pop = 1'b1;
          base_n   = fifo_q[0];
          state_n  = S_PREFETCH;
        end
`endif
      end
      default: state_n = S_IDLE;
    endcase

    if (aborting) begin
      state_n = S_FLUSH;
      err_n   = 1'b1;
    end

`ifdef LENET_SCHED_QUEUE_EN
    fifo_push  = i_start && !direct_take && !aborting && ((fifo_cnt_q != 2'd2) || fifo_pop);
    fifo_cnt_n = aborting ? 2'd0 : fifo_cnt_q + 2'(fifo_push) - 2'(fifo_pop);
    push_idx   = 1'(fifo_cnt_q - 2'(fifo_pop));
    ready_n    = (fifo_cnt_n != 2'd2);
`else
    ready_n    = (state_n == S_IDLE);
`endif
    busy_n   = (state_n != S_IDLE);
    rd_en_n  = (state_n == S_PREFETCH) || ((state_n == S_STREAM) && (pix_n != PIX_LAST));
    addr_n   = '0;
    if (state_n == S_PREFETCH)    addr_n = base_n;
    else if (state_n == S_STREAM) addr_n = base_n + ADDR_W'(pix_n) + ADDR_W'(1);
    ce_n     = (state_n == S_STREAM) || (state_n == S_COMPUTE);
    stream_n = (state_n == S_STREAM);
    flush_n  = (state_n == S_FLUSH);
    error_n  = flush_n && err_n;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      pix_q    <= '0;
      to_q     <= '0;
      got_q    <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      ce_q     <= 1'b0;
      stream_q <= 1'b0;
      flush_q  <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_n;
      base_q   <= base_n;
      pix_q    <= pix_n;
      to_q     <= to_n;
      got_q    <= got_n;
      err_q    <= err_n;
      ready_q  <= ready_n;
      busy_q   <= busy_n;
      rd_en_q  <= rd_en_n;
      addr_q   <= addr_n;
      ce_q     <= ce_n;
      stream_q <= stream_n;
      flush_q  <= flush_n;
      error_q  <= error_n;
      rv_q     <= capture;
      if (capture) result_q <= i_core_cls_result;
    end
  end

`ifdef LENET_SCHED_QUEUE_EN
  // Pending-frame queue; head is always entry 0
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      fifo_cnt_q <= '0;
    end else begin
      fifo_cnt_q <= fifo_cnt_n;
      if (fifo_pop)  fifo_q[0] <= fifo_q[1];
      if (fifo_push) fifo_q[push_idx] <= i_base_addr;
    end
  end
`endif

  // ce drops combinationally on abort so the core never sees the aborting cycle
  assign o_core_ce      = ce_q && !i_abort;
  assign o_core_fmap    = stream_q ? i_mem_rdata : '0;
  assign o_ready        = ready_q;
  assign o_busy         = busy_q;
  assign o_mem_rd_en    = rd_en_q;
  assign o_mem_addr     = addr_q;
  assign o_core_rst_end = flush_q;
  assign o_done         = flush_q;
  assign o_error        = error_q;
  assign o_result       = result_q;
  assign o_result_valid = rv_q;

endmodule

// File: tb/tb_lenet_frame_scheduler.sv
// Scoreboard bench for lenet_frame_scheduler: RAM and core are modelled here, expected pixel
// streams and frame outcomes are derived from the frame rules and checked by a separate monitor.
module tb_lenet_frame_scheduler;
  localparam int unsigned I_SIZE1     = 32;
  localparam int unsigned I_BW1       = 8;
  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned TIMEOUT_CYC = 50;
  localparam int N  = int'(I_SIZE1 * I_SIZE1);
  localparam int TO = int'(TIMEOUT_CYC);

  logic              clk, global_rst_n, i_start, i_abort;
  logic [ADDR_W-1:0] i_base_addr, o_mem_addr;
  logic              o_ready, o_busy, o_mem_rd_en, o_core_ce, o_core_rst_end;
  logic [I_BW1-1:0]  i_mem_rdata, o_core_fmap;
  logic [3:0]        i_core_cls_result, o_result;
  logic              i_core_cls_en, i_core_cls_end, o_result_valid, o_done, o_error;

  typedef struct {
    int err;
    int res;
    int rv;
    int rd;
  } end_t;

  logic [7:0] ram [65536];
  int   exp_pix_q[$];
  end_t end_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   rd_cnt = 0;
  int   rv_cnt = 0;
  int   last_res = 0;

  lenet_frame_scheduler #(
    .I_SIZE1(I_SIZE1), .I_BW1(I_BW1), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .global_rst_n(global_rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_abort(i_abort), .o_ready(o_ready), .o_busy(o_busy), .o_mem_rd_en(o_mem_rd_en),
    .o_mem_addr(o_mem_addr), .i_mem_rdata(i_mem_rdata), .o_core_ce(o_core_ce),
    .o_core_fmap(o_core_fmap), .o_core_rst_end(o_core_rst_end),
    .i_core_cls_result(i_core_cls_result), .i_core_cls_en(i_core_cls_en),
    .i_core_cls_end(i_core_cls_end), .o_result(o_result), .o_result_valid(o_result_valid),
    .o_done(o_done), .o_error(o_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous pixel RAM, one-cycle read latency; garbage when not read
  always @(posedge clk) i_mem_rdata <= o_mem_rd_en ? ram[o_mem_addr] : 8'h5A;

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name, input int act, input int exp);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Monitor: pops expected pixels on every ce cycle and a frame outcome on every done
  always @(negedge clk) begin
    end_t e;
    if (!global_rst_n) begin
      exp_pix_q.delete();
      end_q.delete();
      rd_cnt = 0;
      rv_cnt = 0;
    end else begin
      if (o_mem_rd_en)    rd_cnt++;
      if (o_result_valid) rv_cnt++;
      if (o_error && !o_done)        fail("error_without_done", 1, 0);
      if (o_core_rst_end != o_done)  fail("rst_end_vs_done", int'(o_core_rst_end), int'(o_done));
      if (o_core_ce) begin
        if (exp_pix_q.size() == 0) fail("ce_extra_cycle", 1, 0);
        else chk("fmap", int'(o_core_fmap), exp_pix_q.pop_front());
      end
      if (o_done) begin
        if (end_q.size() == 0) fail("done_unexpected", 1, 0);
        else begin
          e = end_q.pop_front();
          chk("error", int'(o_error), e.err);
          chk("result", int'(o_result), e.res);
          chk("result_valid_pulses", rv_cnt, e.rv);
          chk("mem_reads", rd_cnt, e.rd);
          chk("ce_at_flush", int'(o_core_ce), 0);
          chk("ce_cycles_missing", exp_pix_q.size(), 0);
          exp_pix_q.delete();
        end
        rd_cnt = 0;
        rv_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_start = 1'b0;
    i_abort = 1'b0;
    i_core_cls_en = 1'b0;
    i_core_cls_end = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_rd_en", int'(o_mem_rd_en), 0);
    chk("rst_addr", int'(o_mem_addr), 0);
    chk("rst_ce", int'(o_core_ce), 0);
    chk("rst_fmap", int'(o_core_fmap), 0);
    chk("rst_rst_end", int'(o_core_rst_end), 0);
    chk("rst_result", int'(o_result), 0);
    chk("rst_result_valid", int'(o_result_valid), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_error", int'(o_error), 0);
  endtask

  // a/b: compute-cycle index of cls_en/cls_end (-1 = never); abort_at: ce-cycle index (-1 = never)
  task automatic run_frame(input logic [15:0] base, input int a, input int b, input logic [3:0] res,
                           input int abort_at, input int stray);
    end_t e;
    int stream_pix, zeros, term, stop_g, c, g, k;
    bit captured, done_seen;
    k = (abort_at >= N) ? abort_at - N : -1;
    if (abort_at >= 0 && abort_at < N) begin
      stream_pix = abort_at;
      zeros      = 0;
      stop_g     = abort_at;
      captured   = 1'b0;
      e.err      = 1;
      e.rd       = (abort_at + 2 < N) ? abort_at + 2 : N;
    end else begin
      stream_pix = N;
      e.rd       = N;
      term       = TO - 1;
      if (b >= 0 && b <= term) term = b;
      if (k >= 0 && k <= term) term = k;
      captured = (a >= 0 && a <= term);
      if (k >= 0 && k == term) begin
        zeros = k; e.err = 1;
      end else if (b >= 0 && b == term) begin
        zeros = term + 1; e.err = (a >= 0 && a <= b) ? 0 : 1;
      end else begin
        zeros = TO; e.err = 1;
      end
      stop_g = N + term;
    end
    if (captured) last_res = int'(res);
    e.res = last_res;
    e.rv  = captured ? 1 : 0;
    for (int i = 0; i < stream_pix; i++) exp_pix_q.push_back(int'(ram[16'(base + 16'(i))]));
    for (int i = 0; i < zeros; i++) exp_pix_q.push_back(0);
    end_q.push_back(e);

    // One idle cycle with core events and abort that must all be ignored
    i_core_cls_en = 1'b1; i_core_cls_end = 1'b1; i_abort = 1'b1;
    i_core_cls_result = 4'($urandom);
    tick();
    chk("idle_stays_idle", int'(o_busy), 0);
    clear_inputs();

    i_start = 1'b1; i_base_addr = base;
    tick();
    i_start = 1'b0; i_base_addr = 16'($urandom);
    chk("prefetch_rd_en", int'(o_mem_rd_en), 1);
    chk("prefetch_addr", int'(o_mem_addr), int'(base));
    chk("prefetch_ce", int'(o_core_ce), 0);
    chk("prefetch_ready", int'(o_ready), 0);
    tick();

    c = 2;
    done_seen = 1'b0;
    while (!done_seen && c < N + TO + 40) begin
      g = c - 2;
      i_abort           = (g == abort_at);
      i_core_cls_en     = (g >= N) && (g - N == a);
      i_core_cls_end    = (g >= N) && (g - N == b);
      i_core_cls_result = (g >= N && g - N == a) ? res : 4'($urandom);
      i_start           = (g == stray);
      i_base_addr       = 16'($urandom);
      #1;
      if (g == abort_at)  chk("abort_ce_drop", int'(o_core_ce), 0);
      else if (g == 0)    chk("first_ce_cycle2", int'(o_core_ce), 1);
      tick();
      c++;
      if (o_done) done_seen = 1'b1;
    end
    if (!done_seen) fail("frame_done_timeout", c, stop_g + 3);
    else begin
      chk("flush_cycle", c, stop_g + 3);
      chk("flush_ready", int'(o_ready), 0);
    end
    clear_inputs();
    tick();
    chk("idle_ready", int'(o_ready), 1);
    chk("idle_busy", int'(o_busy), 0);
  endtask

  task automatic run_reset_mid(input logic [15:0] base, input int at_pix);
    for (int i = 0; i < N; i++) exp_pix_q.push_back(int'(ram[16'(base + 16'(i))]));
    i_start = 1'b1; i_base_addr = base;
    tick();
    i_start = 1'b0;
    tick();
    repeat (at_pix) tick();
    global_rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 global_rst_n = 1'b1;
    last_res = 0;
    tick();
  endtask

  initial begin
    int kind, a, b, ab, stray;
    global_rst_n = 1'b1;
    i_base_addr = '0;
    i_core_cls_result = '0;
    clear_inputs();
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < N; i++) ram[16'(16'h0100 + 16'(i))] = 8'(i);
    #2 global_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    global_rst_n = 1'b1;
    tick();

    run_frame(16'h0100, 5, 15, 4'd3, -1, -1);      // nominal
    run_frame(16'hFFF0, 2, 4, 4'd9, -1, 37);       // address wrap, stray start ignored
    run_frame(16'h2000, -1, -1, 4'd5, -1, -1);     // timeout
    run_frame(16'h3000, 6, 6, 4'd7, -1, -1);       // cls_en and cls_end together
    run_frame(16'h4000, -1, 8, 4'd2, -1, -1);      // end without result
    run_frame(16'h5000, 3, 10, 4'd1, 500, -1);     // abort at pixel 500
    run_frame(16'h6000, 2, 9, 4'd4, N + 4, -1);    // abort in compute after capture
    run_reset_mid(16'h0100, 300);
    run_frame(16'h0100, 5, 15, 4'd3, -1, -1);

    for (int f = 0; f < 10; f++) begin
      kind = int'($urandom_range(0, 4));
      a    = int'($urandom_range(0, 10));
      b    = a + int'($urandom_range(0, 10));
      ab   = -1;
      case (kind)
        1: b = a;
        2: begin
          b = -1;
          a = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 45));
        end
        3: begin
          b = int'($urandom_range(0, 20));
          a = ($urandom_range(0, 1) == 1) ? -1 : b + 1 + int'($urandom_range(0, 5));
        end
        4: ab = int'($urandom_range(0, N + 25));
        default: ;
      endcase
      stray = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N - 1)) : -1;
      run_frame(16'($urandom), a, b, 4'($urandom), ab, stray);
    end

    repeat (3) tick();
    chk("no_pending_pixels", exp_pix_q.size(), 0);
    chk("no_pending_frames", end_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
